// File: rtl/mat_vec_result_drain_if.sv
// mat_vec_result_drain_if: capture-in and element-stream-out channels of the result drain
interface mat_vec_result_drain_if #(
  parameter int TILE_ENG = 2,
  parameter int MAT_R = 8,
  parameter int OUT_BITS = 4,
  parameter int TE_W = ($clog2(TILE_ENG) > 0 ? $clog2(TILE_ENG) : 1),
  parameter int ROW_W = ($clog2(MAT_R) > 0 ? $clog2(MAT_R) : 1)
);
  logic cap_valid;
  logic cap_ready;
  logic [TILE_ENG-1:0][MAT_R-1:0][OUT_BITS-1:0] cap_vecs;
  logic out_valid;
  logic out_ready;
  logic signed [OUT_BITS-1:0] out_data;
  logic [TE_W-1:0] out_te;
  logic [ROW_W-1:0] out_row;
  logic out_last;
  logic [7:0] frame_cnt;
  modport slave (
    input cap_valid, cap_vecs, out_ready,
    output cap_ready, out_valid, out_data, out_te, out_row, out_last, frame_cnt
  );
  modport master (
    output cap_valid, cap_vecs, out_ready,
    input cap_ready, out_valid, out_data, out_te, out_row, out_last, frame_cnt
  );
endinterface

// File: rtl/mat_vec_result_drain.sv
// mat_vec_result_drain: snapshots the tile-engine result array and streams it one element per beat
// Optional DRAIN_CHECKSUM_EN appends an XOR-of-all-elements tail beat to each frame.
module mat_vec_result_drain #(
  parameter int TILE_ENG = 2,
  parameter int MAT_R = 8,
  parameter int OUT_BITS = 4,
  parameter int TE_W = ($clog2(TILE_ENG) > 0 ? $clog2(TILE_ENG) : 1),
  parameter int ROW_W = ($clog2(MAT_R) > 0 ? $clog2(MAT_R) : 1)
) (
  input logic i_clock,
  input logic i_reset,
  mat_vec_result_drain_if.slave io_bus
);
`ifdef DRAIN_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, DRAIN, TAIL} state_t;
`else
  typedef enum logic {IDLE, DRAIN} state_t;
`endif
  state_t r_state, w_next;
  logic [TILE_ENG-1:0][MAT_R-1:0][OUT_BITS-1:0] r_cap;
  logic [TE_W-1:0] r_te;
  logic [ROW_W-1:0] r_row;
  logic [7:0] r_frame_cnt;
  logic w_cap_fire, w_beat_fire, w_el_fire, w_row_end, w_last_el, w_frame_done;
`ifdef DRAIN_CHECKSUM_EN
  logic [OUT_BITS-1:0] w_xor;
  always_comb begin
    w_xor = '0;
    for (int t = 0; t < TILE_ENG; t++)
      for (int r = 0; r < MAT_R; r++)
        w_xor = w_xor ^ r_cap[t][r];
  end
`endif
  always_comb begin
    w_row_end = r_row == ROW_W'(MAT_R - 1);
    w_last_el = w_row_end && (r_te == TE_W'(TILE_ENG - 1));
    io_bus.cap_ready = r_state == IDLE;
    io_bus.out_valid = r_state != IDLE;
    w_cap_fire = io_bus.cap_valid && io_bus.cap_ready;
    w_beat_fire = io_bus.out_valid && io_bus.out_ready;
    w_el_fire = w_beat_fire && r_state == DRAIN;
    io_bus.out_te = r_state == DRAIN ? r_te : '0;
    io_bus.out_row = r_state == DRAIN ? r_row : '0;
    io_bus.frame_cnt = r_frame_cnt;
`ifdef DRAIN_CHECKSUM_EN
    io_bus.out_data = r_state == DRAIN ? r_cap[r_te][r_row] : r_state == TAIL ? w_xor : '0;
    io_bus.out_last = r_state == TAIL;
    w_frame_done = w_beat_fire && r_state == TAIL;
    w_next = w_cap_fire ? DRAIN : (w_el_fire && w_last_el) ? TAIL : w_frame_done ? IDLE : r_state;
`else
    io_bus.out_data = r_state == DRAIN ? r_cap[r_te][r_row] : '0;
    io_bus.out_last = r_state == DRAIN && w_last_el;
    w_frame_done = w_el_fire && w_last_el;
    w_next = w_cap_fire ? DRAIN : w_frame_done ? IDLE : r_state;
`endif
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_cap <= '0;
      r_te <= '0;
      r_row <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap_fire) begin
        r_cap <= io_bus.cap_vecs;
        r_te <= '0;
        r_row <= '0;
      end else if (w_el_fire) begin
        r_row <= w_row_end ? '0 : r_row + 1'b1;
        r_te <= w_row_end ? r_te + 1'b1 : r_te;
      end
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mat_vec_result_drain.sv
// tb_mat_vec_result_drain: scoreboard bench for the result drain (default and DRAIN_CHECKSUM_EN builds)
module tb_mat_vec_result_drain;
  localparam int TE = 2;
  localparam int MR = 8;
  localparam int OB = 4;
  localparam int N = TE * MR;
`ifdef DRAIN_CHECKSUM_EN
  localparam int FLEN = N + 1;
`else
  localparam int FLEN = N;
`endif
  typedef struct packed {
    logic [OB-1:0] d;
    logic [0:0] te;
    logic [2:0] row;
    logic last;
  } beat_t;
  typedef logic [TE-1:0][MR-1:0][OB-1:0] arr_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  mat_vec_result_drain_if #(.TILE_ENG(TE), .MAT_R(MR), .OUT_BITS(OB)) bus ();
  mat_vec_result_drain #(.TILE_ENG(TE), .MAT_R(MR), .OUT_BITS(OB)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .io_bus(bus)
  );
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_frames = 0;
  beat_t sb[$];

  task automatic push_frame(input arr_t a);
    logic [OB-1:0] x;
    x = '0;
    for (int t = 0; t < TE; t++)
      for (int r = 0; r < MR; r++) begin
        beat_t b;
        x = x ^ a[t][r];
        b.d = a[t][r];
        b.te = 1'(t);
        b.row = 3'(r);
`ifdef DRAIN_CHECKSUM_EN
        b.last = 1'b0;
`else
        b.last = (t == TE - 1) && (r == MR - 1);
`endif
        sb.push_back(b);
      end
`ifdef DRAIN_CHECKSUM_EN
    sb.push_back('{d: x, te: 1'b0, row: 3'd0, last: 1'b1});
`endif
  endtask

  task automatic capture(input arr_t a);
    bus.cap_vecs = a;
    bus.cap_valid = 1'b1;
    checks++;
    if (bus.cap_ready !== 1'b1) begin
      failures++;
      $display("FAIL capture_ready got=%b want=1", bus.cap_ready);
    end
    push_frame(a);
    @(negedge clk);
    bus.cap_valid = 1'b0;
  endtask

  task automatic drain(input int mode);
    int i;
    logic held;
    beat_t saved, cur, exp;
    i = 0;
    held = 1'b0;
    while (sb.size() > 0 && i < 400) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      cur = {bus.out_data, bus.out_te, bus.out_row, bus.out_last};
      if (held) begin
        checks++;
        if (cur !== saved) begin
          failures++;
          $display("FAIL stall_hold got=%h want=%h", cur, saved);
        end
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL out_valid cycle=%0d got=%b want=1", i, bus.out_valid);
      end
      if (bus.out_ready) begin
        exp = sb.pop_front();
        checks++;
        if (cur !== exp) begin
          failures++;
          $display("FAIL beat d/te/row/last got=%h/%h/%h/%b want=%h/%h/%h/%b",
                   cur.d, cur.te, cur.row, cur.last, exp.d, exp.te, exp.row, exp.last);
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
        saved = cur;
      end
      i++;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout left=%0d want=0", sb.size());
      sb.delete();
    end
    exp_frames++;
    if (mode == 0) begin
      checks++;
      if (i != FLEN) begin
        failures++;
        $display("FAIL frame_cycles got=%0d want=%0d", i, FLEN);
      end
    end
    checks++;
    if (bus.cap_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_frame cap_ready=%b out_valid=%b want=1/0", bus.cap_ready, bus.out_valid);
    end
    checks++;
    if (bus.frame_cnt !== exp_frames) begin
      failures++;
      $display("FAIL frame_cnt got=%0d want=%0d", bus.frame_cnt, exp_frames);
    end
  endtask

  function automatic arr_t ramp();
    arr_t a;
    for (int t = 0; t < TE; t++)
      for (int r = 0; r < MR; r++) a[t][r] = 4'(t * 8 + r);
    return a;
  endfunction

  function automatic arr_t rnd();
    arr_t a;
    for (int t = 0; t < TE; t++)
      for (int r = 0; r < MR; r++) a[t][r] = 4'($urandom_range(0, 15));
    return a;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_frames = '0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cap_valid = 1'b0;
    bus.cap_vecs = '0;
    bus.out_ready = 1'b0;
    do_reset();
    checks++;
    if (bus.cap_ready !== 1'b1) begin failures++; $display("FAIL rst_cap_ready got=%b want=1", bus.cap_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 4'sd0) begin failures++; $display("FAIL rst_out_data got=%h want=0", bus.out_data); end
    checks++;
    if (bus.out_te !== 1'b0 || bus.out_row !== 3'd0) begin
      failures++;
      $display("FAIL rst_index te=%h row=%h want=0/0", bus.out_te, bus.out_row);
    end
    checks++;
    if (bus.out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b want=0", bus.out_last); end
    checks++;
    if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL rst_frame_cnt got=%0d want=0", bus.frame_cnt); end
  endtask

  task automatic test_stream();
    capture(ramp());
    drain(0);
  endtask

  task automatic test_backpressure();
    capture(ramp());
    drain(1);
  endtask

  task automatic test_capture_ignored();
    arr_t a2;
    a2 = rnd();
    capture(rnd());
    bus.cap_vecs = a2;
    bus.cap_valid = 1'b1;
    drain(0);
    push_frame(a2);
    @(negedge clk);
    bus.cap_valid = 1'b0;
    drain(0);
  endtask

  task automatic test_reset_mid();
    beat_t exp, cur;
    capture(rnd());
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur = {bus.out_data, bus.out_te, bus.out_row, bus.out_last};
      exp = sb.pop_front();
      checks++;
      if (cur !== exp) begin
        failures++;
        $display("FAIL pre_reset_beat got=%h want=%h", cur, exp);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL mid_rst_frame_cnt got=%0d want=0", bus.frame_cnt); end
    rst_n = 1'b1;
    sb.delete();
    exp_frames = '0;
    @(negedge clk);
    capture(rnd());
    drain(0);
  endtask

`ifdef DRAIN_CHECKSUM_EN
  task automatic test_checksum();
    arr_t a;
    for (int t = 0; t < TE; t++)
      for (int r = 0; r < MR; r++) a[t][r] = 4'd3;
    a[1][7] = 4'hF;
    capture(a);
    checks++;
    if (sb[N].d !== 4'hC) begin
      failures++;
      $display("FAIL checksum_model got=%h want=c", sb[N].d);
    end
    drain(0);
  endtask
`endif

  task automatic test_wrap();
    do_reset();
    for (int f = 0; f < 256; f++) begin
      capture(rnd());
      drain(f % 3 == 0 ? 1 : 0);
    end
    checks++;
    if (bus.frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL frame_cnt_wrap got=%0d want=0", bus.frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_capture_ignored();
    test_reset_mid();
`ifdef DRAIN_CHECKSUM_EN
    test_checksum();
`endif
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
